// File: rtl/sprw_wb_queue.sv
// Writeback queue for the SPARROW SIMD pipeline: a tag pipe tracks destination registers until the
// result appears on sprw_out, then a credit-gated FIFO presents it to the register-file arbiter.
module sprw_wb_queue #(
   parameter int DEPTH = 4,
   parameter int LAT   = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     holdn,
   input  logic                     flush,
   input  logic                     issue_valid,
   input  logic [4:0]               issue_rd,
   output logic                     issue_ready,
   input  logic [31:0]              sprw_out,
   output logic                     wb_valid,
   output logic [4:0]               wb_rd,
   output logic [31:0]              wb_data,
   input  logic                     wb_ready,
   output logic [$clog2(DEPTH):0]   inflight,
   output logic                     overflow_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [LAT-1:0] r_tag_v;
   logic [4:0]     r_tag_rd [LAT];
   logic [4:0]     r_mem_rd [DEPTH];
   logic [31:0]    r_mem_data [DEPTH];
   logic [AW-1:0]  r_wr_ptr;
   logic [AW-1:0]  r_rd_ptr;
   logic [CW-1:0]  r_count;
   logic           r_ovf;

   logic [CW-1:0]  w_tag_cnt;
   logic           w_accept;
   logic           w_illegal;
   logic           w_capture;
   logic           w_push;
   logic           w_push_ok;
   logic           w_pop;
   logic           w_full;

   always_comb begin
      w_tag_cnt = '0;
      for (int i = 0; i < LAT; i++) begin
         w_tag_cnt = w_tag_cnt + CW'(r_tag_v[i]);
      end
   end

   // Credit counts both tags still in the pipe and results waiting in the FIFO
   assign inflight     = w_tag_cnt + r_count;
   assign issue_ready  = (inflight < CW'(DEPTH));
   assign w_accept     = issue_valid & issue_ready & holdn & ~flush;
   assign w_illegal    = issue_valid & ~issue_ready & holdn;
   assign w_capture    = holdn & r_tag_v[LAT-1] & ~flush;
   assign w_push       = w_capture & (r_tag_rd[LAT-1] != 5'd0);
   assign w_full       = (r_count == CW'(DEPTH));
   assign wb_valid     = (r_count != '0);
   assign w_pop        = wb_valid & wb_ready;
   assign w_push_ok    = w_push & (~w_full | w_pop);
   assign wb_rd        = wb_valid ? r_mem_rd[r_rd_ptr]   : 5'd0;
   assign wb_data      = wb_valid ? r_mem_data[r_rd_ptr] : 32'd0;
   assign overflow_err = r_ovf;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tag_v <= '0;
      end else if (flush) begin
         r_tag_v <= '0;
      end else if (holdn) begin
         r_tag_v[0] <= w_accept;
         for (int i = 1; i < LAT; i++) begin
            r_tag_v[i] <= r_tag_v[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (holdn) begin
         r_tag_rd[0] <= issue_rd;
         for (int i = 1; i < LAT; i++) begin
            r_tag_rd[i] <= r_tag_rd[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_mem_rd[r_wr_ptr]   <= r_tag_rd[LAT-1];
         r_mem_data[r_wr_ptr] <= sprw_out;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_ovf    <= 1'b0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)     r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push_ok, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
         // Sticky: an issue without credit, or a push that found no room
         if (w_illegal | (w_push & ~w_push_ok)) r_ovf <= 1'b1;
      end
   end

endmodule

// File: tb/tb_sprw_wb_queue.sv
// Bench for sprw_wb_queue: directed scenarios plus random traffic, checked each cycle against a
// queue-based model of in-flight instructions and buffered results.
module tb_sprw_wb_queue;

   localparam int DEPTH = 4;
   localparam int LAT   = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        holdn;
   logic        flush;
   logic        issue_valid;
   logic [4:0]  issue_rd;
   logic        issue_ready;
   logic [31:0] sprw_out;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        wb_ready;
   logic [2:0]  inflight;
   logic        overflow_err;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [4:0] rd;
      int         age;
   } tag_t;
   typedef struct {
      logic [4:0]  rd;
      logic [31:0] d;
   } ent_t;

   tag_t       m_pipe[$];
   ent_t       m_fifo[$];
   bit         m_ovf;
   logic [4:0] obs_rd[$];

   sprw_wb_queue #(.DEPTH(DEPTH), .LAT(LAT)) dut (
      .clk(clk), .rst(rst), .holdn(holdn), .flush(flush),
      .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
      .sprw_out(sprw_out), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
      .wb_ready(wb_ready), .inflight(inflight), .overflow_err(overflow_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int m_inflight();
      return m_pipe.size() + m_fifo.size();
   endfunction

   task automatic model_reset();
      m_pipe.delete();
      m_fifo.delete();
      m_ovf = 0;
   endtask

   // One clock edge of the reference model, using the inputs currently driven
   task automatic model_edge();
      tag_t nxt[$];
      bit   ready;
      bit   pop;
      bit   accept;
      int   fsize;
      ready  = m_inflight() < DEPTH;
      pop    = (m_fifo.size() > 0) && wb_ready;
      accept = issue_valid && ready && holdn && !flush;
      fsize  = m_fifo.size();
      if (issue_valid && !ready && holdn) m_ovf = 1;
      if (pop) void'(m_fifo.pop_front());
      if (flush) begin
         m_pipe.delete();
      end else if (holdn) begin
         foreach (m_pipe[i]) begin
            if (m_pipe[i].age == LAT - 1) begin
               if (m_pipe[i].rd != 5'd0) begin
                  if (fsize < DEPTH || pop) m_fifo.push_back('{m_pipe[i].rd, sprw_out});
                  else m_ovf = 1;
               end
            end else begin
               nxt.push_back('{m_pipe[i].rd, m_pipe[i].age + 1});
            end
         end
         if (accept) nxt.push_back('{issue_rd, 0});
         m_pipe = nxt;
      end
   endtask

   task automatic check_all();
      bit ne;
      ne = m_fifo.size() > 0;
      chk("wb_valid", 32'(wb_valid), 32'(ne));
      chk("wb_rd", 32'(wb_rd), ne ? 32'(m_fifo[0].rd) : 32'd0);
      chk("wb_data", wb_data, ne ? m_fifo[0].d : 32'd0);
      chk("issue_ready", 32'(issue_ready), 32'(m_inflight() < DEPTH));
      chk("inflight", 32'(inflight), 32'(m_inflight()));
      chk("overflow_err", 32'(overflow_err), 32'(m_ovf));
   endtask

   task automatic tick();
      @(negedge clk);
      check_all();
      if (wb_valid && wb_ready) obs_rd.push_back(wb_rd);
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle();
      issue_valid = 1'b0;
      issue_rd    = 5'd0;
      flush       = 1'b0;
      holdn       = 1'b1;
   endtask

   initial begin
      rst = 1'b1;
      idle();
      sprw_out = 32'd0;
      wb_ready = 1'b1;
      model_reset();
      #1;
      chk("reset_wb_valid", 32'(wb_valid), 32'd0);
      chk("reset_inflight", 32'(inflight), 32'd0);
      chk("reset_issue_ready", 32'(issue_ready), 32'd1);
      chk("reset_wb_data", wb_data, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Single op
      issue_valid = 1'b1; issue_rd = 5'd5; tick();
      idle(); tick();
      sprw_out = 32'hDEADBEEF; tick();
      sprw_out = 32'd0;
      chk("single_valid", 32'(wb_valid), 32'd1);
      chk("single_rd", 32'(wb_rd), 32'd5);
      chk("single_data", wb_data, 32'hDEADBEEF);
      tick();
      chk("single_one_cycle", 32'(wb_valid), 32'd0);

      // Hold stretch
      issue_valid = 1'b1; issue_rd = 5'd7; tick();
      idle(); holdn = 1'b0; tick(); tick();
      holdn = 1'b1; tick();
      chk("hold_not_early", 32'(wb_valid), 32'd0);
      sprw_out = 32'h12345678; tick();
      sprw_out = 32'd0;
      chk("hold_valid", 32'(wb_valid), 32'd1);
      chk("hold_rd", 32'(wb_rd), 32'd7);
      chk("hold_data", wb_data, 32'h12345678);
      tick();

      // Backpressure and credit
      wb_ready = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         if (k >= 5) chk("bp_ready_low", 32'(issue_ready), 32'd0);
         issue_valid = issue_ready;
         issue_rd    = 5'(k);
         sprw_out    = $urandom;
         tick();
      end
      idle();
      tick(); tick();
      chk("bp_inflight", 32'(inflight), 32'd4);
      chk("bp_no_ovf", 32'(overflow_err), 32'd0);

      // Illegal issue while out of credit
      issue_valid = 1'b1; issue_rd = 5'd20; tick();
      idle();
      chk("illegal_ovf", 32'(overflow_err), 32'd1);
      chk("illegal_dropped", 32'(inflight), 32'd4);
      obs_rd.delete();
      wb_ready = 1'b1;
      repeat (6) tick();
      chk("drain_cnt", 32'(obs_rd.size()), 32'd4);
      for (int i = 0; i < 4; i++) chk("drain_order", 32'(obs_rd[i]), 32'(i + 1));
      chk("drain_ready", 32'(issue_ready), 32'd1);
      chk("ovf_sticky", 32'(overflow_err), 32'd1);

      // Flush with an entry already queued
      wb_ready = 1'b0;
      issue_valid = 1'b1; issue_rd = 5'd9; tick();
      idle(); sprw_out = 32'h99; tick(); tick();
      obs_rd.delete();
      issue_valid = 1'b1; issue_rd = 5'd3; tick();
      issue_rd = 5'd4; flush = 1'b1; tick();
      idle();
      chk("flush_inflight", 32'(inflight), 32'd1);
      tick();
      wb_ready = 1'b1; tick();
      chk("flush_after_pop", 32'(inflight), 32'd0);
      repeat (4) tick();
      chk("flush_wb_cnt", 32'(obs_rd.size()), 32'd1);
      chk("flush_wb_rd", 32'(obs_rd[0]), 32'd9);

      // x0 destination is discarded but frees its credit
      issue_valid = 1'b1; issue_rd = 5'd0; tick();
      idle();
      chk("x0_inflight", 32'(inflight), 32'd1);
      tick(); tick();
      chk("x0_credit", 32'(inflight), 32'd0);
      chk("x0_no_valid", 32'(wb_valid), 32'd0);

      // Random traffic
      repeat (1500) begin
         holdn       = ($urandom % 5) != 0;
         flush       = ($urandom % 20) == 0;
         wb_ready    = ($urandom % 3) != 0;
         issue_valid = (($urandom % 8) == 0) ? 1'b1 : (issue_ready && ($urandom % 2 == 0));
         issue_rd    = 5'($urandom % 32);
         sprw_out    = $urandom;
         tick();
      end

      // Asynchronous reset mid-drain
      idle();
      wb_ready = 1'b1;
      repeat (6) tick();
      wb_ready = 1'b0;
      issue_valid = 1'b1; issue_rd = 5'd11; sprw_out = 32'hB0; tick();
      issue_rd = 5'd12; sprw_out = 32'hB1; tick();
      idle(); sprw_out = 32'hB2; tick(); sprw_out = 32'hB3; tick(); tick();
      chk("pre_rst_inflight", 32'(inflight), 32'd2);
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      chk("rst_wb_valid", 32'(wb_valid), 32'd0);
      chk("rst_inflight", 32'(inflight), 32'd0);
      chk("rst_issue_ready", 32'(issue_ready), 32'd1);
      chk("rst_ovf", 32'(overflow_err), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
